setclr_reg_responder: RTL and testbench

- Bus responder for the multi-cycle CPU's data-memory port: the CPU initiates, this block answers.
- Holds NREG 32-bit registers.
- Supports four operations: plain write, bit-set (OR), bit-clear (AND-NOT) and read.
- Uses a valid/ready request channel and a valid/ready response channel, with a programmable wait-state count so the CPU's multi-cycle memory states are exercised.

---
 rtl/setclr_reg_responder_pkg.sv | 22 ++
 rtl/setclr_reg_responder_alu.sv | 68 ++++++
 rtl/setclr_reg_responder.sv | 130 +++++++++++++
 tb/tb_setclr_reg_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/setclr_reg_responder_pkg.sv
// setclr_reg_responder_pkg
// Shared encodings for the set/clear register responder and its ALU.
// Holds the request opcode values and the responder FSM state values so
// both the top level and the ALU decode the same constants.
package setclr_reg_responder_pkg;

    typedef logic [1:0] op_t;
    typedef logic [1:0] state_t;

    // Request opcodes carried on req_op
    localparam op_t OP_READ  = 2'b00;
    localparam op_t OP_WRITE = 2'b01;
    localparam op_t OP_SET   = 2'b10;
    localparam op_t OP_CLR   = 2'b11;

    // Responder FSM states
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_WAIT = 2'd1;
    localparam state_t S_EXEC = 2'd2;
    localparam state_t S_RESP = 2'd3;

endpackage

// File: rtl/setclr_reg_responder_alu.sv
// or32 / and32 / setclr_alu
// Bitwise gate building blocks and the combinational operation unit that
// turns (op, old register value, data/mask) into the new register value.
//
// or32  : a, b (32b in) -> y = a | b
// and32 : a, b (32b in) -> y = a & b
// setclr_alu:
//   op      in  2   operation code (read/write/set/clear)
//   old_val in  32  current register contents
//   mask    in  32  write data or bit mask
//   new_val out 32  register contents after the operation

module or32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a | b;
endmodule

module and32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a & b;
endmodule

module setclr_alu
    import setclr_reg_responder_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] old_val,
    input  logic [31:0] mask,
    output logic [31:0] new_val
);
    logic [31:0] set_val;
    logic [31:0] clr_val;
    logic [31:0] mask_n;

    // Clearing is an AND with the complemented mask
    assign mask_n = ~mask;

    or32 u_or (
        .a (old_val),
        .b (mask),
        .y (set_val)
    );

    and32 u_and (
        .a (old_val),
        .b (mask_n),
        .y (clr_val)
    );

    // Read passes the old value through so the caller can write it back
    // unconditionally without disturbing the register.
    always_comb begin
        new_val = old_val;
        case (op)
            OP_WRITE: new_val = mask;
            OP_SET:   new_val = set_val;
            OP_CLR:   new_val = clr_val;
            default:  new_val = old_val;
        endcase
    end

endmodule

// File: rtl/setclr_reg_responder.sv
// setclr_reg_responder
// Data-memory-port responder for the multi-cycle CPU. Accepts one request
// at a time, waits WAIT cycles, executes read/write/set/clear on one of
// NREG 32-bit registers, then presents a response until it is taken.
//
// Ports:
//   clk        in  1   rising-edge clock
//   rst_n      in  1   asynchronous active-low reset
//   req_valid  in  1   request present
//   req_ready  out 1   responder idle and able to accept
//   req_op     in  2   00 read, 01 write, 10 set, 11 clear
//   req_addr   in  32  word address
//   req_wdata  in  32  write data / bit mask
//   rsp_valid  out 1   response present
//   rsp_ready  in  1   initiator takes response
//   rsp_rdata  out 32  register value after the operation (0 on error)
//   rsp_err    out 1   address out of range
//   busy       out 1   high whenever not idle

module setclr_reg_responder
    import setclr_reg_responder_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [1:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] regs [NREG];

    logic [AW-1:0] idx;
    logic          in_range;
    logic [31:0]   alu_out;

    assign idx      = addr_q[AW-1:0];
    assign in_range = (addr_q[31:AW] == '0);

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    setclr_alu u_alu (
        .op      (op_q),
        .old_val (regs[idx]),
        .mask    (wdata_q),
        .new_val (alu_out)
    );

    // Transaction sequencing. The request is captured only at accept, so
    // later activity on the request pins cannot affect the operation. The
    // counter is loaded with WAIT-1 and the FSM leaves WAIT on the cycle it
    // reads zero, giving exactly WAIT cycles of wait state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            op_q      <= OP_READ;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (WAIT > 0) begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_EXEC;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_EXEC: begin
                    rsp_rdata <= in_range ? alu_out : 32'h0;
                    rsp_err   <= ~in_range;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Register file. A read writes back the unchanged value from the ALU,
    // so only the range check gates the update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (state == S_EXEC && in_range) begin
            regs[idx] <= alu_out;
        end
    end

endmodule

// File: tb/tb_setclr_reg_responder.sv
// tb_setclr_reg_responder
// Directed bench with a response scoreboard for setclr_reg_responder.
// A WAIT=2 instance carries most of the sequence; a WAIT=0 instance checks
// the short-latency build.

module tb_setclr_reg_responder;
    import setclr_reg_responder_pkg::*;

    localparam int WAIT_N = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [1:0]  req_op;
    logic [31:0] req_addr, req_wdata, rsp_rdata;

    logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
    logic [1:0]  z_req_op;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;

    int          errors = 0;
    int          checks = 0;
    rsp_t        sbq[$];
    logic [31:0] model [8];

    always #5 clk = ~clk;

    setclr_reg_responder #(.NREG(8), .AW(3), .WAIT(WAIT_N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    setclr_reg_responder #(.NREG(8), .AW(3), .WAIT(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (z_req_valid),
        .req_ready (z_req_ready),
        .req_op    (z_req_op),
        .req_addr  (z_req_addr),
        .req_wdata (z_req_wdata),
        .rsp_valid (z_rsp_valid),
        .rsp_ready (z_rsp_ready),
        .rsp_rdata (z_rsp_rdata),
        .rsp_err   (z_rsp_err),
        .busy      (z_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction on the WAIT=2 instance. The expected response is
    // computed from the bench's own register model and queued at accept;
    // hold>0 keeps rsp_ready low for that many RESP cycles while a competing
    // request is offered.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int hold);
        int          lat;
        int          busy_cnt;
        int          guard;
        rsp_t        exp;
        logic [31:0] held_data;
        logic        held_err;

        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("req_ready_at_accept", 32'(req_ready), 32'd1);

        exp.err   = (addr >= 32'd8);
        exp.rdata = 32'h0;
        if (!exp.err) begin
            case (op)
                OP_WRITE: model[addr[2:0]] = wdata;
                OP_SET:   model[addr[2:0]] = model[addr[2:0]] | wdata;
                OP_CLR:   model[addr[2:0]] = model[addr[2:0]] & ~wdata;
                default:  ;
            endcase
            exp.rdata = model[addr[2:0]];
        end
        sbq.push_back(exp);

        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!rsp_valid && lat < 50) begin
            busy_cnt += int'(busy);
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_op    = 2'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        busy_cnt += int'(busy);
        checkOutput("latency", 32'(lat), 32'(WAIT_N + 2));
        checkOutput("busy_cycles", 32'(busy_cnt), 32'(WAIT_N + 2));

        if (hold > 0) begin
            held_data = rsp_rdata;
            held_err  = rsp_err;
            for (int i = 0; i < hold; i++) begin
                req_valid = 1'b1;
                req_op    = OP_WRITE;
                req_addr  = 32'd7;
                req_wdata = 32'hCAFE_F00D;
                @(posedge clk); #1;
                checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
                checkOutput("bp_rdata_stable", rsp_rdata, held_data);
                checkOutput("bp_err_stable", 32'(rsp_err), 32'(held_err));
                checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end

        if (sbq.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp = sbq.pop_front();
            checkOutput("rsp_rdata", rsp_rdata, exp.rdata);
            checkOutput("rsp_err", 32'(rsp_err), 32'(exp.err));
        end

        @(posedge clk); #1;
        checkOutput("rsp_valid_dropped", 32'(rsp_valid), 32'd0);
        checkOutput("idle_after_rsp", 32'(busy), 32'd0);
        checkOutput("req_ready_after_rsp", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_op      = OP_READ;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        rsp_ready   = 1'b1;
        z_req_valid = 1'b0;
        z_req_op    = OP_READ;
        z_req_addr  = 32'h0;
        z_req_wdata = 32'h0;
        z_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);

        $display("[TB] read after reset");
        applyStimulus(OP_READ, 32'd3, 32'h0, 0);

        $display("[TB] write / set / clear sequence");
        applyStimulus(OP_WRITE, 32'd1, 32'hA5A5_0000, 0);
        applyStimulus(OP_SET,   32'd1, 32'h0000_00FF, 0);
        applyStimulus(OP_CLR,   32'd1, 32'hA000_000F, 0);
        applyStimulus(OP_READ,  32'd1, 32'h0, 0);

        $display("[TB] zero and all-ones masks");
        applyStimulus(OP_WRITE, 32'd4, 32'h1357_9BDF, 0);
        applyStimulus(OP_SET,   32'd4, 32'h0000_0000, 0);
        applyStimulus(OP_CLR,   32'd4, 32'h0000_0000, 0);
        applyStimulus(OP_SET,   32'd6, 32'hFFFF_FFFF, 0);
        applyStimulus(OP_CLR,   32'd6, 32'hFFFF_FFFF, 0);

        $display("[TB] out-of-range addresses");
        applyStimulus(OP_WRITE, 32'd8,          32'hFFFF_FFFF, 0);
        applyStimulus(OP_WRITE, 32'h8000_0001,  32'hFFFF_FFFF, 0);
        for (int a = 0; a < 8; a++) applyStimulus(OP_READ, 32'(a), 32'h0, 0);

        $display("[TB] response backpressure");
        applyStimulus(OP_READ, 32'd1, 32'h0, 5);
        applyStimulus(OP_READ, 32'd7, 32'h0, 0);

        $display("[TB] request pins toggled during wait");
        applyStimulus(OP_WRITE, 32'd2, 32'h1234_5678, 0);
        applyStimulus(OP_READ,  32'd2, 32'h0, 0);

        $display("[TB] reset during wait");
        applyStimulus(OP_WRITE, 32'd5, 32'hDEAD_BEEF, 0);
        req_op    = OP_WRITE;
        req_addr  = 32'd0;
        req_wdata = 32'hFFFF_FFFF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("busy_before_abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
        checkOutput("abort_rsp_rdata", rsp_rdata, 32'h0);
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen += int'(rsp_valid);
        end
        checkOutput("no_rsp_after_abort", 32'(seen), 32'd0);
        applyStimulus(OP_READ, 32'd0, 32'h0, 0);
        applyStimulus(OP_READ, 32'd5, 32'h0, 0);

        $display("[TB] WAIT=0 instance");
        z_req_op    = OP_WRITE;
        z_req_addr  = 32'd2;
        z_req_wdata = 32'h1234_5678;
        z_req_valid = 1'b1;
        checkOutput("w0_req_ready", 32'(z_req_ready), 32'd1);
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        z_req_wdata = 32'h0BAD_0BAD;
        lat = 1;
        while (!z_rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("w0_latency", 32'(lat), 32'd2);
        checkOutput("w0_rdata", z_rsp_rdata, 32'h1234_5678);
        checkOutput("w0_err", 32'(z_rsp_err), 32'd0);
        @(posedge clk); #1;
        checkOutput("w0_rsp_dropped", 32'(z_rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
